// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded control and operands for Execute,
// with hazard stall (hold), flush (bubble) and saturating stall/flush event counters.
package id_ex_pkg;
   typedef enum logic [2:0] {
      ALUOP_NONE        = 3'd0,
      ALUOP_RTYPE       = 3'd1,
      ALUOP_ITYPE_ARITH = 3'd2,
      ALUOP_LOAD        = 3'd3,
      ALUOP_STORE       = 3'd4,
      ALUOP_BRANCH      = 3'd5,
      ALUOP_JUMP        = 3'd6,
      ALUOP_LUI         = 3'd7
   } alu_op_e;
endpackage

module id_ex_pipeline_register
   import id_ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 id_valid_i,
   input  logic [XLEN-1:0]      id_pc_i,
   input  logic [XLEN-1:0]      id_pc_plus4_i,
   input  logic [XLEN-1:0]      id_rs1_data_i,
   input  logic [XLEN-1:0]      id_rs2_data_i,
   input  logic [XLEN-1:0]      id_imm_i,
   input  logic [4:0]           id_rs1_addr_i,
   input  logic [4:0]           id_rs2_addr_i,
   input  logic [4:0]           id_rd_addr_i,
   input  alu_op_e              id_ALUOp_i,
   input  logic [2:0]           id_funct3_i,
   input  logic                 id_funct7_i,
   input  logic                 id_alu_src_b_i,
   input  logic                 id_mem_read_i,
   input  logic                 id_mem_write_i,
   input  logic                 id_reg_write_i,
   input  logic [1:0]           id_wb_sel_i,
   input  logic                 id_branch_i,
   input  logic                 id_jump_i,
   output logic                 ex_valid_o,
   output logic [XLEN-1:0]      ex_pc_o,
   output logic [XLEN-1:0]      ex_pc_plus4_o,
   output logic [XLEN-1:0]      ex_rs1_data_o,
   output logic [XLEN-1:0]      ex_rs2_data_o,
   output logic [XLEN-1:0]      ex_imm_o,
   output logic [4:0]           ex_rs1_addr_o,
   output logic [4:0]           ex_rs2_addr_o,
   output logic [4:0]           ex_rd_addr_o,
   output alu_op_e              ex_ALUOp_o,
   output logic [2:0]           ex_funct3_o,
   output logic                 ex_funct7_o,
   output logic                 ex_alu_src_b_o,
   output logic                 ex_mem_read_o,
   output logic                 ex_mem_write_o,
   output logic                 ex_reg_write_o,
   output logic [1:0]           ex_wb_sel_o,
   output logic                 ex_branch_o,
   output logic                 ex_jump_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);

   // All-zero encodes a bubble: valid=0, ALUOP_NONE, no side effects.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
      alu_op_e         alu_op;
      logic [2:0]      funct3;
      logic            funct7;
      logic            alu_src_b;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic [1:0]      wb_sel;
      logic            branch;
      logic            jump;
   } ex_bundle_t;

   ex_bundle_t           ex_q, ex_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   always_comb begin
      ex_d        = ex_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush_i) begin
         ex_d        = '0;
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (stall_i) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else if (!id_valid_i) begin
         ex_d = '0;
      end else begin
         ex_d.valid     = 1'b1;
         ex_d.pc        = id_pc_i;
         ex_d.pc_plus4  = id_pc_plus4_i;
         ex_d.rs1_data  = id_rs1_data_i;
         ex_d.rs2_data  = id_rs2_data_i;
         ex_d.imm       = id_imm_i;
         ex_d.rs1_addr  = id_rs1_addr_i;
         ex_d.rs2_addr  = id_rs2_addr_i;
         ex_d.rd_addr   = id_rd_addr_i;
         ex_d.alu_op    = id_ALUOp_i;
         ex_d.funct3    = id_funct3_i;
         ex_d.funct7    = id_funct7_i;
         ex_d.alu_src_b = id_alu_src_b_i;
         ex_d.mem_read  = id_mem_read_i;
         ex_d.mem_write = id_mem_write_i;
         ex_d.reg_write = id_reg_write_i;
         ex_d.wb_sel    = id_wb_sel_i;
         ex_d.branch    = id_branch_i;
         ex_d.jump      = id_jump_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid_o     = ex_q.valid;
   assign ex_pc_o        = ex_q.pc;
   assign ex_pc_plus4_o  = ex_q.pc_plus4;
   assign ex_rs1_data_o  = ex_q.rs1_data;
   assign ex_rs2_data_o  = ex_q.rs2_data;
   assign ex_imm_o       = ex_q.imm;
   assign ex_rs1_addr_o  = ex_q.rs1_addr;
   assign ex_rs2_addr_o  = ex_q.rs2_addr;
   assign ex_rd_addr_o   = ex_q.rd_addr;
   assign ex_ALUOp_o     = ex_q.alu_op;
   assign ex_funct3_o    = ex_q.funct3;
   assign ex_funct7_o    = ex_q.funct7;
   assign ex_alu_src_b_o = ex_q.alu_src_b;
   assign ex_mem_read_o  = ex_q.mem_read;
   assign ex_mem_write_o = ex_q.mem_write;
   assign ex_reg_write_o = ex_q.reg_write;
   assign ex_wb_sel_o    = ex_q.wb_sel;
   assign ex_branch_o    = ex_q.branch;
   assign ex_jump_o      = ex_q.jump;
   assign stall_cnt_o    = stall_cnt_q;
   assign flush_cnt_o    = flush_cnt_q;

endmodule
